// File: rtl/gate_sweep_checker.sv
// Exhaustive stimulus sweep and response checker for a combinational gate.
// Each pattern is held for HOLD_CYCLES settle cycles, then dut_x is compared
// against the selected reduction of the pattern for one CHECK cycle.
module gate_sweep_checker #(
  parameter int N_IN        = 2,
  parameter int HOLD_CYCLES = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [2:0]      op,
  input  logic            dut_x,
  output logic [N_IN-1:0] pattern,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_fail,
  output logic            fail_valid,
  output logic            cfg_err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Hold counter only has to reach HOLD_CYCLES-1.
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0]   HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_ONE   = 1;
  localparam logic [N_IN-1:0] PAT_ONE   = 1;
  localparam logic [N_IN:0]   ERR_ONE   = 1;

  logic [1:0]    state_reg;
  logic [CW-1:0] hold_cnt_reg;
  logic [2:0]    op_reg;
  logic          expected;

  // Reference response of the latched gate function for the current pattern.
  always_comb begin
    expected = 1'b0;
    case (op_reg)
      3'd0:    expected = &pattern;
      3'd1:    expected = |pattern;
      3'd2:    expected = ^pattern;
      3'd3:    expected = ~&pattern;
      3'd4:    expected = ~|pattern;
      3'd5:    expected = ~^pattern;
      default: expected = 1'b0;
    endcase
  end

  // Sweep sequencer: settle, check, advance pattern, report at the end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      hold_cnt_reg <= '0;
      op_reg       <= '0;
      pattern      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_cnt      <= '0;
      first_fail   <= '0;
      fail_valid   <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            if (op <= 3'd5) begin
              op_reg       <= op;
              pattern      <= '0;
              err_cnt      <= '0;
              fail_valid   <= 1'b0;
              first_fail   <= '0;
              pass         <= 1'b0;
              busy         <= 1'b1;
              hold_cnt_reg <= '0;
              state_reg    <= ST_SETTLE;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
            pattern   <= '0;
            pass      <= 1'b0;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + CNT_ONE;
            if (hold_cnt_reg == HOLD_LAST) begin
              state_reg <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (abort) begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
            pattern   <= '0;
            pass      <= 1'b0;
          end else begin
            if (dut_x != expected) begin
              err_cnt <= err_cnt + ERR_ONE;
              if (!fail_valid) begin
                first_fail <= pattern;
                fail_valid <= 1'b1;
              end
            end
            if (&pattern) begin
              state_reg <= ST_DONE;
              done      <= 1'b1;
            end else begin
              pattern      <= pattern + PAT_ONE;
              hold_cnt_reg <= '0;
              state_reg    <= ST_SETTLE;
            end
          end
        end
        ST_DONE: begin
          // err_cnt already holds the final CHECK update here.
          pass      <= (err_cnt == '0);
          busy      <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: table-driven sweeps, randomized sweeps
// checked against a truth-table model, and abort/reset/cfg corner cases.
module tb_gate_sweep_checker;

  localparam int N  = 3;
  localparam int H  = 4;
  localparam int NP = 1 << N;
  localparam int L  = NP * (H + 1);

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         abort;
  logic [2:0]   op;
  logic         dut_x;
  logic [N-1:0] pattern;
  logic         busy;
  logic         done;
  logic         pass;
  logic [N:0]   err_cnt;
  logic [N-1:0] first_fail;
  logic         fail_valid;
  logic         cfg_err;

  int           gate_sel;
  logic [7:0]   fault_mask;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  typedef struct {
    int         op;
    int         gate;
    logic [7:0] mask;
    int         exp_err;
    int         exp_ff;
    int         exp_fv;
    int         exp_pass;
  } vec_t;

  vec_t vecs[8];

  gate_sweep_checker #(.N_IN(N), .HOLD_CYCLES(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .op         (op),
    .dut_x      (dut_x),
    .pattern    (pattern),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_cnt    (err_cnt),
    .first_fail (first_fail),
    .fail_valid (fail_valid),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  // Truth of a gate function by counting ones: 0 AND .. 5 XNOR, 6 stuck0, 7 stuck1.
  function automatic logic func_val(input int f, input int p);
    int ones;
    ones = $countones(p);
    case (f)
      0: return (ones == N);
      1: return (ones != 0);
      2: return (ones % 2 == 1);
      3: return (ones != N);
      4: return (ones == 0);
      5: return (ones % 2 == 0);
      6: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Emulated gate under test, with optional per-pattern fault injection.
  always_comb dut_x = func_val(gate_sel, int'(pattern)) ^ fault_mask[pattern];

  // Model: mismatch statistics over patterns 0..upto-1.
  task automatic model(input int op_i, input int gate_i, input logic [7:0] mask_i,
                       input int upto, output int e, output int ff, output int fv);
    e = 0; ff = 0; fv = 0;
    for (int p = 0; p < upto; p++) begin
      if (func_val(op_i, p) != (func_val(gate_i, p) ^ mask_i[p])) begin
        if (fv == 0) begin ff = p; fv = 1; end
        e++;
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run_sweep(input int op_i, input int gate_i, input logic [7:0] mask_i,
                           input int mid_start, input bit abort_done, input bit abort_with_start,
                           input int exp_err, input int exp_ff, input int exp_fv, input int exp_pass);
    int n;
    bit seq_ok;
    bit saw_cfg;
    gate_sel   = gate_i;
    fault_mask = mask_i;
    @(negedge clk);
    op = 3'(op_i); start = 1'b1; abort = abort_with_start;
    @(negedge clk);
    start = 1'b0; abort = 1'b0; op = 3'($urandom % 8);
    check("busy_after_start", int'(busy), 1);
    n = 1; seq_ok = 1'b1; saw_cfg = 1'b0;
    while (!done && n <= L + 5) begin
      if (int'(pattern) != (n - 1) / (H + 1)) seq_ok = 1'b0;
      if (cfg_err) saw_cfg = 1'b1;
      if (mid_start > 0 && n == mid_start) begin
        start = 1'b1; op = 3'($urandom % 8);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("done_cycle", n, L + 1);
    check("pattern_sequence", int'(seq_ok), 1);
    check("no_cfg_err_busy", int'(saw_cfg), 0);
    check("err_cnt", int'(err_cnt), exp_err);
    check("first_fail", int'(first_fail), exp_ff);
    check("fail_valid", int'(fail_valid), exp_fv);
    check("busy_in_done", int'(busy), 1);
    abort = abort_done;
    @(negedge clk);
    abort = 1'b0;
    check("done_one_cycle", int'(done), 0);
    check("busy_after_done", int'(busy), 0);
    check("pass", int'(pass), exp_pass);
    check("pattern_held", int'(pattern), NP - 1);
    $display("sweep op=%0d gate=%0d mask=%02h err=%0d ff=%0d fv=%0d pass=%0d",
             op_i, gate_i, mask_i, err_cnt, first_fail, fail_valid, pass);
  endtask

  initial begin
    int e, ff, fv, n, o, g;
    logic [7:0] m;
    vecs[0] = '{0, 0, 8'h00, 0, 0, 0, 1};
    vecs[1] = '{3, 0, 8'h00, 8, 0, 1, 0};
    vecs[2] = '{1, 1, 8'h00, 0, 0, 0, 1};
    vecs[3] = '{1, 6, 8'h00, 7, 1, 1, 0};
    vecs[4] = '{2, 1, 8'h00, 3, 3, 1, 0};
    vecs[5] = '{5, 2, 8'h00, 8, 0, 1, 0};
    vecs[6] = '{4, 7, 8'h00, 7, 1, 1, 0};
    vecs[7] = '{2, 2, 8'h20, 1, 5, 1, 0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; op = 3'd0;
    gate_sel = 0; fault_mask = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_outputs", int'({pattern, busy, done, pass, err_cnt, first_fail, fail_valid, cfg_err}), 0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven sweeps.
    for (int i = 0; i < 8; i++)
      run_sweep(vecs[i].op, vecs[i].gate, vecs[i].mask, 0, 1'b0, 1'b0,
                vecs[i].exp_err, vecs[i].exp_ff, vecs[i].exp_fv, vecs[i].exp_pass);

    // Start mid-sweep ignored, abort in DONE ignored, abort+start in IDLE.
    run_sweep(1, 6, 8'h00, 12, 1'b0, 1'b0, 7, 1, 1, 0);
    run_sweep(0, 0, 8'h00, 0, 1'b1, 1'b0, 0, 0, 0, 1);
    run_sweep(2, 2, 8'h00, 0, 1'b0, 1'b1, 0, 0, 0, 1);

    // cfg_err on reserved op; status from the last sweep stays put.
    @(negedge clk);
    op = 3'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("cfg_err_pulse", int'(cfg_err), 1);
    check("cfg_busy", int'(busy), 0);
    check("cfg_pass_kept", int'(pass), 1);
    @(negedge clk);
    check("cfg_err_one_cycle", int'(cfg_err), 0);
    check("cfg_still_idle", int'(busy), 0);
    $display("cfg_err test op=6 done");

    // Abort during pattern 2: partial results kept, no done.
    gate_sel = 6; fault_mask = 8'h00;
    op = 3'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (int'(pattern) != 2 && n < 200) begin @(negedge clk); n++; end
    check("abort_reach_p2", int'(pattern), 2);
    repeat ($urandom_range(0, H)) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    model(1, 6, 8'h00, 2, e, ff, fv);
    check("abort_busy", int'(busy), 0);
    check("abort_pattern", int'(pattern), 0);
    check("abort_err_cnt", int'(err_cnt), e);
    check("abort_first_fail", int'(first_fail), ff);
    check("abort_fail_valid", int'(fail_valid), fv);
    check("abort_pass", int'(pass), 0);
    n = 0;
    repeat (L + 10) begin @(negedge clk); if (done) n++; end
    check("abort_no_done", n, 0);
    $display("abort test err=%0d ff=%0d fv=%0d", err_cnt, first_fail, fail_valid);

    // Reset mid-sweep while pattern=1 in SETTLE.
    gate_sel = 1; op = 3'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (int'(pattern) != 1 && n < 200) begin @(negedge clk); n++; end
    repeat ($urandom_range(0, H - 1)) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_outputs", int'({pattern, busy, done, pass, err_cnt, first_fail, fail_valid, cfg_err}), 0);
    @(negedge clk);
    rst = 1'b0;
    $display("mid-sweep reset applied");
    run_sweep(1, 1, 8'h00, 0, 1'b0, 1'b0, 0, 0, 0, 1);

    // Randomized sweeps against the model.
    for (int i = 0; i < 6; i++) begin
      o = int'($urandom_range(0, 5));
      g = int'($urandom_range(0, 7));
      m = ($urandom % 2 == 0) ? 8'h00 : 8'($urandom);
      model(o, g, m, NP, e, ff, fv);
      run_sweep(o, g, m, int'($urandom_range(0, L - 1)), 1'($urandom % 2), 1'($urandom % 2),
                e, ff, fv, (e == 0) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
